// File: rtl/ca_row_engine.sv
// Elementary cellular automaton row engine: advances a WIDTH-cell row one
// generation per clock under a latched 8-bit Wolfram rule, with selectable
// edge handling, a generation budget and optional halt on a fixed point.
module ca_row_engine #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_row,
  input  logic             start,
  input  logic [7:0]       rule,
  input  logic [1:0]       boundary_mode,
  input  logic [GEN_W-1:0] num_gens,
  input  logic             stop_on_stable,
  output logic [WIDTH-1:0] row,
  output logic             busy,
  output logic             done,
  output logic             stable,
  output logic [GEN_W-1:0] gen_count
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] row_q, row_d;
  logic [GEN_W-1:0] gen_count_q, gen_count_d;
  logic [GEN_W-1:0] remaining_q, remaining_d;
  logic [7:0]       rule_q, rule_d;
  logic [1:0]       mode_q, mode_d;
  logic             sos_q, sos_d;
  logic             stable_q, stable_d;
  logic             done_q, done_d;

  logic             left_edge, right_edge;
  logic [WIDTH+1:0] ext_row;
  logic [WIDTH-1:0] next_row;
  logic             fixed_point;
  logic             last_gen;

  // Neighbourhood lookup: ext_row[0] is R of cell 0, ext_row[WIDTH+1] is L of the top cell.
  always_comb begin
    left_edge  = 1'b0;
    right_edge = 1'b0;
    case (mode_q)
      2'b01: begin
        left_edge  = 1'b1;
        right_edge = 1'b1;
      end
      2'b10: begin
        left_edge  = row_q[0];
        right_edge = row_q[WIDTH-1];
      end
      2'b11: begin
        left_edge  = row_q[WIDTH-1];
        right_edge = row_q[0];
      end
      default: ;
    endcase
    ext_row = {left_edge, row_q, right_edge};
    for (int i = 0; i < WIDTH; i++) begin
      next_row[i] = rule_q[ext_row[i+2 -: 3]];
    end
  end

  assign fixed_point = sos_q && (next_row == row_q);
  assign last_gen    = (remaining_q == GEN_W'(1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!load && start && (num_gens != '0)) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (fixed_point || last_gen) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath and flag next values for the current state.
  always_comb begin
    row_d       = row_q;
    gen_count_d = gen_count_q;
    remaining_d = remaining_q;
    rule_d      = rule_q;
    mode_d      = mode_q;
    sos_d       = sos_q;
    stable_d    = stable_q;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          row_d       = load_row;
          gen_count_d = '0;
          stable_d    = 1'b0;
        end else if (start) begin
          stable_d = 1'b0;
          if (num_gens == '0) begin
            done_d = 1'b1;
          end else begin
            rule_d      = rule;
            mode_d      = boundary_mode;
            sos_d       = stop_on_stable;
            remaining_d = num_gens;
          end
        end
      end
      StRun: begin
        if (fixed_point) begin
          stable_d = 1'b1;
          done_d   = 1'b1;
        end else begin
          row_d       = next_row;
          remaining_d = remaining_q - 1'b1;
          if (gen_count_q != '1) begin
            gen_count_d = gen_count_q + 1'b1;
          end
          if (last_gen) begin
            done_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q       <= '0;
      gen_count_q <= '0;
      remaining_q <= '0;
      rule_q      <= '0;
      mode_q      <= '0;
      sos_q       <= 1'b0;
      stable_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      row_q       <= row_d;
      gen_count_q <= gen_count_d;
      remaining_q <= remaining_d;
      rule_q      <= rule_d;
      mode_q      <= mode_d;
      sos_q       <= sos_d;
      stable_q    <= stable_d;
      done_q      <= done_d;
    end
  end

  assign row       = row_q;
  assign busy      = (state_q == StRun);
  assign done      = done_q;
  assign stable    = stable_q;
  assign gen_count = gen_count_q;

endmodule

// File: tb/tb_ca_row_engine.sv
// Directed bench for ca_row_engine: a GEN_W=16 instance carries the main
// checks, a GEN_W=4 instance shares the stimulus for the saturation check.
module tb_ca_row_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [7:0]  load_row = '0;
  logic        start = 1'b0;
  logic [7:0]  rule = '0;
  logic [1:0]  boundary_mode = '0;
  logic [15:0] num_gens = '0;
  logic [3:0]  num_gens4 = '0;
  logic        stop_on_stable = 1'b0;

  logic [7:0]  row, row4;
  logic        busy, done, stable, busy4, done4, stable4;
  logic [15:0] gen_count;
  logic [3:0]  gen_count4;

  int n_checks = 0;
  int n_pass   = 0;
  int cnt;

  always #5 clk = ~clk;

  ca_row_engine #(.WIDTH(8), .GEN_W(16)) dut (
    .clk(clk), .rst(rst), .load(load), .load_row(load_row), .start(start),
    .rule(rule), .boundary_mode(boundary_mode), .num_gens(num_gens),
    .stop_on_stable(stop_on_stable), .row(row), .busy(busy), .done(done),
    .stable(stable), .gen_count(gen_count)
  );

  ca_row_engine #(.WIDTH(8), .GEN_W(4)) dut4 (
    .clk(clk), .rst(rst), .load(load), .load_row(load_row), .start(start),
    .rule(rule), .boundary_mode(boundary_mode), .num_gens(num_gens4),
    .stop_on_stable(stop_on_stable), .row(row4), .busy(busy4), .done(done4),
    .stable(stable4), .gen_count(gen_count4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Leaves the bench on the negedge after the loading edge.
  task automatic do_load(input logic [7:0] val);
    @(negedge clk);
    load = 1'b1;
    load_row = val;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Leaves the bench on the negedge after the start edge (E0).
  task automatic start_run(input logic [7:0] r, input logic [1:0] m, input int n, input logic s);
    @(negedge clk);
    start = 1'b1;
    rule = r;
    boundary_mode = m;
    num_gens = 16'(n);
    num_gens4 = 4'(n);
    stop_on_stable = s;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts busy cycles until done, then checks done is a single-cycle pulse.
  task automatic wait_done(output int busy_cycles);
    int guard = 0;
    busy_cycles = 0;
    while (done !== 1'b1 && guard < 200) begin
      if (busy) busy_cycles++;
      guard++;
      @(negedge clk);
    end
    check("done_timeout", 32'(guard < 200), 1);
    check("done_with_busy", busy, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_row", row, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_stable", stable, 0);
    check("rst_gen", gen_count, 0);
    rst = 1'b0;

    // Rule 90, zero boundary, generation by generation.
    do_load(8'b0001_0000);
    check("load_row", row, 8'b0001_0000);
    start_run(8'd90, 2'b00, 3, 1'b0);
    check("r90_e0_busy", busy, 1);
    check("r90_e0_row", row, 8'b0001_0000);
    @(negedge clk);
    check("r90_g1", row, 8'b0010_1000);
    @(negedge clk);
    check("r90_g2", row, 8'b0100_0100);
    check("r90_g2_busy", busy, 1);
    @(negedge clk);
    check("r90_g3", row, 8'b1010_1010);
    check("r90_done", done, 1);
    check("r90_busy_low", busy, 0);
    check("r90_gen", gen_count, 3);
    @(negedge clk);
    check("r90_done_pulse", done, 0);

    // Busy count for a fresh 3-gen run.
    do_load(8'b0001_0000);
    start_run(8'd90, 2'b00, 3, 1'b0);
    wait_done(cnt);
    check("r90_busy_cycles", cnt, 3);

    // Wrap and one boundaries.
    do_load(8'b0000_0001);
    start_run(8'd90, 2'b10, 1, 1'b0);
    wait_done(cnt);
    check("wrap_row", row, 8'b1000_0010);
    do_load(8'h00);
    start_run(8'd90, 2'b01, 1, 1'b0);
    wait_done(cnt);
    check("one_row", row, 8'b1000_0001);

    // Reflect: rule 252 is L|C, so the top cell reflects itself and cell 6 sees cell 7.
    do_load(8'b1000_0000);
    start_run(8'd252, 2'b11, 1, 1'b0);
    wait_done(cnt);
    check("reflect_row", row, 8'b1100_0000);

    // Identity rule with and without early halt.
    do_load(8'hA5);
    start_run(8'd204, 2'b00, 10, 1'b1);
    wait_done(cnt);
    check("sos_busy", cnt, 1);
    check("sos_stable", stable, 1);
    check("sos_row", row, 8'hA5);
    check("sos_gen", gen_count, 0);
    start_run(8'd204, 2'b00, 0, 1'b0);
    check("zero_busy", busy, 0);
    check("zero_done", done, 1);
    check("zero_stable_clr", stable, 0);
    check("zero_row", row, 8'hA5);
    @(negedge clk);
    check("zero_done_pulse", done, 0);
    start_run(8'd204, 2'b00, 10, 1'b0);
    wait_done(cnt);
    check("nosos_busy", cnt, 10);
    check("nosos_gen", gen_count, 10);
    check("nosos_stable", stable, 0);
    check("nosos_row", row, 8'hA5);

    // Load and start together: load wins, no run.
    @(negedge clk);
    load = 1'b1;
    start = 1'b1;
    load_row = 8'h3C;
    num_gens = 16'd4;
    @(negedge clk);
    load = 1'b0;
    start = 1'b0;
    check("ls_row", row, 8'h3C);
    check("ls_busy", busy, 0);
    check("ls_gen", gen_count, 0);
    @(negedge clk);
    check("ls_busy2", busy, 0);
    check("ls_done", done, 0);

    // Disturbances mid-run are ignored.
    do_load(8'b0001_0000);
    start_run(8'd90, 2'b00, 5, 1'b0);
    load = 1'b1;
    start = 1'b1;
    load_row = 8'hFF;
    rule = 8'd0;
    boundary_mode = 2'b01;
    num_gens = 16'd1;
    @(negedge clk);
    load = 1'b0;
    start = 1'b0;
    wait_done(cnt);
    check("dist_row", row, 8'b0000_0010);
    check("dist_gen", gen_count, 5);

    // Reset at E2 of a 5-gen run.
    do_load(8'b0001_0000);
    start_run(8'd90, 2'b00, 5, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mrst_row", row, 0);
    check("mrst_busy", busy, 0);
    check("mrst_gen", gen_count, 0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    check("mrst_no_done", cnt, 0);

    // Saturation on the 4-bit instance: 20 generations across two runs.
    do_load(8'b0001_0000);
    start_run(8'd90, 2'b10, 10, 1'b0);
    wait_done(cnt);
    start_run(8'd90, 2'b10, 10, 1'b0);
    wait_done(cnt);
    check("sat_gen16", gen_count, 20);
    check("sat_gen4", gen_count4, 15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ca_row_engine.md
Name: ca_row_engine

Overview:
- Sequential elementary cellular automaton engine. Holds a WIDTH-cell row and advances it one generation per clock under any 8-bit Wolfram rule.
- Supports selectable boundary handling, a programmable generation count, and optional early halt when the row stops changing.
- Successor to the single-cell next-state logic. It sits between the seed/config source and the row display/capture logic.

Parameters:
- WIDTH, 8, number of cells in the row (>=3).
- GEN_W, 16, width of the generation-count and remaining-count registers.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  pulse; copies load_row into the row (honoured in IDLE only).
- load_row  in  WIDTH  seed row; bit WIDTH-1 is the leftmost cell.
- start  in  1  pulse; begins a run (honoured in IDLE only).
- rule  in  8  Wolfram rule number; latched on start.
- boundary_mode  in  2  00 zero, 01 one, 10 wrap, 11 reflect; latched on start.
- num_gens  in  GEN_W  number of generations to run; latched on start.
- stop_on_stable  in  1  when 1, halt early on a fixed point; latched on start.
- row  out  WIDTH  current row state (registered).
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when a run ends.
- stable  out  1  last run ended on a fixed point; sticky until the next load or start.
- gen_count  out  GEN_W  generations applied since the last load; saturates at all-ones.

Behaviour:
- Reset (async, any state): row=0, busy=0, done=0, stable=0, gen_count=0, FSM=IDLE, all latched config=0.
- Cell update: next[i] = rule_q[{L,C,R}], where C=row[i], L=row[i+1], R=row[i-1]. All cells update in parallel from the same old row.
- Missing edge neighbours (L of cell WIDTH-1, R of cell 0), by boundary_mode:
  - zero: 0.
  - one: 1.
  - wrap: L of cell WIDTH-1 is row[0]; R of cell 0 is row[WIDTH-1].
  - reflect: the missing neighbour equals the edge cell itself.
- FSM state IDLE:
  - load=1: row<=load_row, gen_count<=0, stable<=0. load wins over a simultaneous start; that start is dropped.
  - start=1, num_gens==0: stay IDLE, stable<=0, done=1 next cycle, row unchanged.
  - start=1, num_gens>0: latch rule/mode/num_gens/stop_on_stable, remaining<=num_gens, stable<=0, go to RUN. busy=1 from the next cycle.
- FSM state RUN, each edge:
  - If stop_on_stable_q and next==row: row unchanged, gen_count unchanged, stable<=1, done<=1, go to IDLE.
  - Otherwise: row<=next, gen_count<=gen_count+1 (saturating), remaining<=remaining-1.
  - If remaining was 1 on that edge: done<=1, go to IDLE.
- Run timing: start sampled at edge E0. Generations are applied at edges E1..En. After En: busy=0, done=1 for exactly one cycle, and row holds generation n.
- Input changes during RUN:
  - load and start are ignored entirely (no queueing).
  - Changes to rule/boundary_mode/num_gens have no effect until the next start.
- done is never asserted together with busy=1.
- rst asserted mid-run: immediate return to the reset state. No done pulse.
- Without stop_on_stable, a fixed point keeps running to num_gens, gen_count still counts, and stable stays 0.

Test Plan:
- WIDTH=8, zero boundary, rule 90, load 8'b00010000, start num_gens=3 -> row after E1/E2/E3 = 00101000 / 01000100 / 10101010; done one cycle after E3; gen_count=3; busy high exactly 3 cycles.
- Wrap boundary, rule 90, load 8'b00000001, num_gens=1 -> row=8'b10000010. Then one-boundary, rule 90, load 0, num_gens=1 -> 8'b10000001.
- Rule 204 (identity), load 8'hA5, stop_on_stable=1, num_gens=10 -> done after 1 RUN cycle, stable=1, row=8'hA5, gen_count=0. Same with stop_on_stable=0 -> 10 cycles busy, gen_count=10, stable=0.
- start with num_gens=0 -> no busy, done pulse next cycle, row unchanged. load and start in the same cycle -> row loaded, no run.
- During a 5-gen run: pulse load with 8'hFF and change rule mid-run -> ignored; result matches an undisturbed run.
- Assert rst at E2 of a 5-gen run -> row=0, busy=0, gen_count=0 immediately, no done.
- GEN_W=4: run 20 generations total across runs -> gen_count saturates at 15.
